// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
//   BCD_W      : bits per BCD digit
//   DIGIT_MAX  : largest legal BCD digit value
//   bcd_width  : total vector width for a given number of digits
package bcd_updown_counter_pkg;

  localparam int         BCD_W     = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic int bcd_width(input int digits);
    return BCD_W * digits;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Signal bundle for one BCD up/down counter stage.
//   master : drives cs/ld/en/cai/up/d, observes q/cao/ill
//   slave  : the counter side of the same bundle
// There is no valid/ready handshake here: every control input is sampled on
// each rising clock edge, and q/cao/ill are continuously valid.
interface bcd_updown_counter_if
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS = 2
);
  localparam int W = bcd_width(DIGITS);

  logic         cs;
  logic         ld;
  logic         en;
  logic         cai;
  logic         up;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         cao;
  logic         ill;

  modport master (
    output cs, ld, en, cai, up, d,
    input  q, cao, ill
  );

  modport slave (
    input  cs, ld, en, cai, up, d,
    output q, cao, ill
  );

endinterface

// File: rtl/bcd_updown_counter_bcd_digit.sv
// One BCD digit: combinational increment/decrement with carry/borrow chain.
//   q_i    : current digit value
//   up_i   : direction, 1 = increment, 0 = decrement
//   cin_i  : carry (up) / borrow (down) request from the lower digit
//   q_o    : digit value after the step
//   cout_o : carry/borrow to the next digit (digit rolled 9->0 or 0->9)
//   ill_o  : digit holds a non-BCD value (A..F)
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic [BCD_W-1:0] q_i,
  input  logic             up_i,
  input  logic             cin_i,
  output logic [BCD_W-1:0] q_o,
  output logic             cout_o,
  output logic             ill_o
);

  always_comb begin
    q_o    = q_i;
    cout_o = 1'b0;
    if (cin_i) begin
      if (up_i) begin
        if (q_i == DIGIT_MAX) begin
          q_o    = '0;
          cout_o = 1'b1;
        end else begin
          q_o = q_i + 4'd1;
        end
      end else begin
        if (q_i == 4'd0) begin
          q_o    = DIGIT_MAX;
          cout_o = 1'b1;
        end else begin
          q_o = q_i - 4'd1;
        end
      end
    end
  end

  assign ill_o = (q_i > DIGIT_MAX);

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascadable multi-digit BCD up/down counter with terminal count TERM.
//   CLK : clock (rising edge)       CD  : async active-high reset
//   CS  : sync clear (top priority) LD  : sync parallel load of D
//   EN  : count enable              CAI : carry-in, must be 1 to count
//   UP  : 1 = up, 0 = down          D   : load data, digit k at D[4k+3:4k]
//   Q   : count value               CAO : cascade carry/borrow (combinational)
//   ILL : some digit of Q is above 9; counting freezes until CS/LD/CD
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int                    DIGITS = 2,
  parameter logic [4*DIGITS-1:0]   TERM   = {DIGITS{4'h9}}
) (
  input  logic                    CLK,
  input  logic                    CD,
  input  logic                    CS,
  input  logic                    LD,
  input  logic                    EN,
  input  logic                    CAI,
  input  logic                    UP,
  input  logic [4*DIGITS-1:0]     D,
  output logic [4*DIGITS-1:0]     Q,
  output logic                    CAO,
  output logic                    ILL
);

  localparam int W = bcd_width(DIGITS);

  logic [W-1:0]      q_q;
  logic [W-1:0]      q_d;
  logic [W-1:0]      step_val;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] dig_ill;
  logic              at_term;
  logic              at_zero;
  logic              cnt_ok;

  // The chain is always asked to step; the register only takes step_val
  // when counting is actually enabled.
  assign carry[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .q_i    (q_q[BCD_W*k +: BCD_W]),
      .up_i   (UP),
      .cin_i  (carry[k]),
      .q_o    (step_val[BCD_W*k +: BCD_W]),
      .cout_o (carry[k+1]),
      .ill_o  (dig_ill[k])
    );
  end

  assign ILL     = |dig_ill;
  assign at_term = (q_q == TERM);
  assign at_zero = (q_q == '0);
  assign cnt_ok  = CAI & EN & ~ILL;
  assign CAO     = cnt_ok & (UP ? at_term : at_zero);
  assign Q       = q_q;

  always_comb begin
    q_d = q_q;
    if (CS) begin
      q_d = '0;
    end else if (LD) begin
      q_d = D;
    end else if (cnt_ok) begin
      if (UP) begin
        // Values above TERM are stepped normally and wrap only at all-9s,
        // which the digit chain already produces as zero.
        q_d = at_term ? '0 : step_val;
      end else begin
        // Borrow out of the top digit happens exactly when Q is zero; the
        // down count then reloads the terminal value instead of all-9s.
        q_d = carry[DIGITS] ? TERM : step_val;
      end
    end
  end

  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic clk;
  logic cd;
  int   checks;
  int   passed;
  logic [15:0] exp_q[$];

  bcd_updown_counter_if #(.DIGITS(2)) bif ();
  bcd_updown_counter_if #(.DIGITS(2)) tif ();
  bcd_updown_counter_if #(.DIGITS(4)) fif ();

  // Cascade pair: two single-digit stages.
  logic       c_ld, c_en, c_cai0, c_up;
  logic [3:0] c_d, c_q0, c_q1;
  logic       c_cao0, c_cao1, c_ill0, c_ill1;

  bcd_updown_counter #(.DIGITS(2)) dut (
    .CLK(clk), .CD(cd), .CS(bif.cs), .LD(bif.ld), .EN(bif.en), .CAI(bif.cai),
    .UP(bif.up), .D(bif.d), .Q(bif.q), .CAO(bif.cao), .ILL(bif.ill)
  );

  bcd_updown_counter #(.DIGITS(2), .TERM(8'h63)) dut63 (
    .CLK(clk), .CD(cd), .CS(tif.cs), .LD(tif.ld), .EN(tif.en), .CAI(tif.cai),
    .UP(tif.up), .D(tif.d), .Q(tif.q), .CAO(tif.cao), .ILL(tif.ill)
  );

  bcd_updown_counter #(.DIGITS(4)) dut4 (
    .CLK(clk), .CD(cd), .CS(fif.cs), .LD(fif.ld), .EN(fif.en), .CAI(fif.cai),
    .UP(fif.up), .D(fif.d), .Q(fif.q), .CAO(fif.cao), .ILL(fif.ill)
  );

  bcd_updown_counter #(.DIGITS(1)) dut_c0 (
    .CLK(clk), .CD(cd), .CS(1'b0), .LD(c_ld), .EN(c_en), .CAI(c_cai0),
    .UP(c_up), .D(c_d), .Q(c_q0), .CAO(c_cao0), .ILL(c_ill0)
  );

  bcd_updown_counter #(.DIGITS(1)) dut_c1 (
    .CLK(clk), .CD(cd), .CS(1'b0), .LD(c_ld), .EN(c_en), .CAI(c_cao0),
    .UP(c_up), .D(c_d), .Q(c_q1), .CAO(c_cao1), .ILL(c_ill1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic int bcd2int(input logic [15:0] v, input int n);
    int r;
    logic [3:0] dg;
    r = 0;
    for (int k = n - 1; k >= 0; k--) begin
      dg = v[4*k +: 4];
      if (dg > 4'd9) return -1;
      r = r * 10 + int'(dg);
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x, input int n);
    logic [15:0] r;
    int t;
    r = '0;
    t = x;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] model_next(input logic [15:0] q, input int n,
      input int term, input logic cs, input logic ld, input logic en,
      input logic cai, input logic up, input logic [15:0] d);
    int v, modv;
    v = bcd2int(q, n);
    modv = 1;
    for (int k = 0; k < n; k++) modv = modv * 10;
    if (cs) return '0;
    if (ld) return d;
    if (!(cai && en) || v < 0) return q;
    if (up) return int2bcd((v == term) ? 0 : (v + 1) % modv, n);
    return int2bcd((v == 0) ? term : v - 1, n);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bif.cs = 0; bif.ld = 0; bif.en = 0; bif.cai = 0; bif.up = 1; bif.d = '0;
    tif.cs = 0; tif.ld = 0; tif.en = 0; tif.cai = 0; tif.up = 1; tif.d = '0;
    fif.cs = 0; fif.ld = 0; fif.en = 0; fif.cai = 0; fif.up = 1; fif.d = '0;
    c_ld = 0; c_en = 0; c_cai0 = 0; c_up = 1; c_d = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_all();
    cd = 1'b1;
    bif.cai = 1; bif.en = 1; bif.up = 0;
    #1;
    checks++;
    if (bif.q !== 8'h00) $display("FAIL reset_q: got %h want 00", bif.q); else passed++;
    checks++;
    if (bif.ill !== 1'b0) $display("FAIL reset_ill: got %b want 0", bif.ill); else passed++;
    checks++;
    if (bif.cao !== 1'b1) $display("FAIL reset_cao_down: got %b want 1", bif.cao); else passed++;
    checks++;
    if (fif.q !== 16'h0000) $display("FAIL reset_q4: got %h want 0000", fif.q); else passed++;
    @(negedge clk);
    cd = 1'b0;
    step();
    checks++;
    if (bif.q !== 8'h99) $display("FAIL release_first_edge: got %h want 99", bif.q); else passed++;
    bif.cai = 0; bif.en = 0;
  endtask

  task automatic test_term63();
    tif.ld = 1; tif.d = 8'h62;
    step();
    tif.ld = 0; tif.cai = 1; tif.en = 1; tif.up = 1;
    #1;
    checks++;
    if (tif.cao !== 1'b0) $display("FAIL t63_cao_at62: got %b want 0", tif.cao); else passed++;
    step();
    checks++;
    if (tif.q !== 8'h63) $display("FAIL t63_reach: got %h want 63", tif.q); else passed++;
    checks++;
    if (tif.cao !== 1'b1) $display("FAIL t63_cao_at63: got %b want 1", tif.cao); else passed++;
    step();
    checks++;
    if (tif.q !== 8'h00) $display("FAIL t63_wrap: got %h want 00", tif.q); else passed++;
    checks++;
    if (tif.cao !== 1'b0) $display("FAIL t63_cao_at00: got %b want 0", tif.cao); else passed++;
    // Above TERM: counts on, wraps only at 99.
    tif.ld = 1; tif.d = 8'h98;
    step();
    tif.ld = 0;
    step();
    checks++;
    if (tif.q !== 8'h99) $display("FAIL t63_above_term: got %h want 99", tif.q); else passed++;
    step();
    checks++;
    if (tif.q !== 8'h00) $display("FAIL t63_above_wrap: got %h want 00", tif.q); else passed++;
    // Down from zero loads TERM.
    tif.up = 0;
    step();
    checks++;
    if (tif.q !== 8'h63) $display("FAIL t63_down_wrap: got %h want 63", tif.q); else passed++;
    tif.en = 0; tif.cai = 0;
  endtask

  task automatic test_down();
    bif.ld = 1; bif.d = 8'h10;
    step();
    bif.ld = 0; bif.cai = 1; bif.en = 1; bif.up = 0;
    step();
    checks++;
    if (bif.q !== 8'h09) $display("FAIL down_10: got %h want 09", bif.q); else passed++;
    bif.ld = 1; bif.d = 8'h00;
    step();
    bif.ld = 0;
    #1;
    checks++;
    if (bif.cao !== 1'b1) $display("FAIL down_cao_at00: got %b want 1", bif.cao); else passed++;
    step();
    checks++;
    if (bif.q !== 8'h99) $display("FAIL down_wrap: got %h want 99", bif.q); else passed++;
    bif.en = 0; bif.cai = 0;
  endtask

  task automatic test_illegal();
    bif.ld = 1; bif.d = 8'h3A; bif.cai = 1; bif.en = 1; bif.up = 1;
    step();
    bif.ld = 0;
    checks++;
    if (bif.q !== 8'h3A) $display("FAIL ill_load: got %h want 3a", bif.q); else passed++;
    checks++;
    if (bif.ill !== 1'b1) $display("FAIL ill_flag: got %b want 1", bif.ill); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bif.q !== 8'h3A || bif.cao !== 1'b0)
        $display("FAIL ill_hold: got q=%h cao=%b want q=3a cao=0", bif.q, bif.cao);
      else passed++;
    end
    bif.cs = 1;
    step();
    bif.cs = 0;
    checks++;
    if (bif.q !== 8'h00 || bif.ill !== 1'b0)
      $display("FAIL ill_clear: got q=%h ill=%b want q=00 ill=0", bif.q, bif.ill);
    else passed++;
    bif.en = 0; bif.cai = 0;
  endtask

  task automatic test_clear_load_async();
    bif.cs = 1; bif.ld = 1; bif.d = 8'h55;
    step();
    bif.cs = 0;
    checks++;
    if (bif.q !== 8'h00) $display("FAIL cs_over_ld: got %h want 00", bif.q); else passed++;
    bif.d = 8'h47;
    step();
    bif.ld = 0; bif.cai = 1; bif.en = 1; bif.up = 1;
    @(negedge clk);
    cd = 1'b1;
    #1;
    checks++;
    if (bif.q !== 8'h00) $display("FAIL async_reset: got %h want 00", bif.q); else passed++;
    #1;
    cd = 1'b0;
    step();
    checks++;
    if (bif.q !== 8'h01) $display("FAIL resume_after_reset: got %h want 01", bif.q); else passed++;
    bif.en = 0; bif.cai = 0;
  endtask

  task automatic test_cascade();
    c_ld = 1; c_d = 4'h9;
    step();
    c_ld = 0; c_en = 1; c_cai0 = 1; c_up = 1;
    #1;
    checks++;
    if (c_q0 !== 4'h9 || c_q1 !== 4'h9 || c_cao0 !== 1'b1)
      $display("FAIL cascade_pre: got q1=%h q0=%h cao0=%b want 9 9 1", c_q1, c_q0, c_cao0);
    else passed++;
    step();
    checks++;
    if (c_q0 !== 4'h0 || c_q1 !== 4'h0)
      $display("FAIL cascade_wrap: got q1=%h q0=%h want 0 0", c_q1, c_q0);
    else passed++;
    c_en = 0; c_cai0 = 0;
  endtask

  task automatic test_four_digit();
    fif.ld = 1; fif.d = 16'h0999;
    step();
    fif.ld = 0; fif.cai = 1; fif.en = 1; fif.up = 1;
    step();
    checks++;
    if (fif.q !== 16'h1000) $display("FAIL d4_up: got %h want 1000", fif.q); else passed++;
    fif.up = 0;
    step();
    checks++;
    if (fif.q !== 16'h0999) $display("FAIL d4_down: got %h want 0999", fif.q); else passed++;
    fif.en = 0; fif.cai = 0;
  endtask

  task automatic test_random();
    logic [15:0] model_q, nxt, dlegal, got;
    int v;
    logic exp_cao, exp_ill;
    bif.cs = 1;
    step();
    bif.cs = 0;
    model_q = '0;
    for (int i = 0; i < 400; i++) begin
      bif.cs  = ($urandom_range(0, 19) == 0);
      bif.ld  = ($urandom_range(0, 14) == 0);
      bif.en  = ($urandom_range(0, 3) != 0);
      bif.cai = ($urandom_range(0, 3) != 0);
      bif.up  = 1'($urandom_range(0, 1));
      dlegal  = int2bcd($urandom_range(0, 99), 2);
      if ($urandom_range(0, 3) == 0) bif.d = 8'($urandom_range(0, 255));
      else                           bif.d = dlegal[7:0];
      #1;
      v = bcd2int(model_q, 2);
      exp_ill = (v < 0);
      exp_cao = bif.cai && bif.en && !exp_ill && (bif.up ? (v == 99) : (v == 0));
      checks++;
      if (bif.cao !== exp_cao || bif.ill !== exp_ill)
        $display("FAIL rand_comb[%0d]: got cao=%b ill=%b want cao=%b ill=%b (q=%h)",
                 i, bif.cao, bif.ill, exp_cao, exp_ill, model_q[7:0]);
      else passed++;
      nxt = model_next(model_q, 2, 99, bif.cs, bif.ld, bif.en, bif.cai, bif.up,
                       {8'h00, bif.d});
      exp_q.push_back(nxt);
      step();
      model_q = exp_q.pop_front();
      got = {8'h00, bif.q};
      checks++;
      if (got !== model_q)
        $display("FAIL rand_q[%0d]: got %h want %h", i, bif.q, model_q[7:0]);
      else passed++;
    end
    bif.cs = 0; bif.ld = 0; bif.en = 0; bif.cai = 0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    passed = 0;
    cd = 1'b0;
    idle_all();
    test_reset();
    test_term63();
    test_down();
    test_illegal();
    test_clear_load_async();
    test_cascade();
    test_four_digit();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2, number of 4-bit BCD digits (1..8).
REQ-002 Parameter TERM, default all digits 9 (BCD), is the terminal count, BCD-encoded, 4*DIGITS bits wide.
REQ-003 Port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port CD, input, 1 bit: asynchronous active-high reset.
REQ-005 Port CS, input, 1 bit: synchronous clear.
REQ-006 Port LD, input, 1 bit: synchronous parallel load.
REQ-007 Port EN, input, 1 bit: count enable.
REQ-008 Port CAI, input, 1 bit: carry-in; counting requires CAI=1.
REQ-009 Port UP, input, 1 bit: direction, 1=up, 0=down.
REQ-010 Port D, input, 4*DIGITS bits: load data; digit k occupies D[4k+3:4k].
REQ-011 Port Q, output, 4*DIGITS bits: count value, same digit layout as D.
REQ-012 Port CAO, output, 1 bit: cascade carry/borrow out, combinational.
REQ-013 Port ILL, output, 1 bit: high when any digit of Q exceeds 9.

Function
REQ-014 Priority each rising CLK edge: CS (Q<=0), else LD (Q<=D verbatim, illegal digits included), else count step, else hold.
REQ-015 Count step occurs only when CAI=1, EN=1 and ILL=0; when ILL=1, Q holds until CS, LD or CD.
REQ-016 Up, Q==TERM: Q<=0 on the next edge.
REQ-017 Up, Q!=TERM: Q<=Q+1 decimal; digit 9 becomes 0 with carry to the next digit; all-9s becomes 0.
REQ-018 Down, Q==0: Q<=TERM on the next edge.
REQ-019 Down, Q!=0: Q<=Q-1 decimal; digit 0 becomes 9 with borrow to the next digit.
REQ-020 Q>TERM, legal BCD: counts normally without clamping; in the up direction it wraps only at all-9s.
REQ-021 CAO = CAI & EN & ~ILL & (UP ? Q==TERM : Q==0); zero-latency, so cascaded stages step on the same edge.
REQ-022 UP may change on any cycle; the new direction applies to the step at the next edge.
REQ-023 LD with CAI=EN=1 loads; no step occurs on that edge.
REQ-024 CS asserted with LD clears.

Reset
REQ-025 CD=1 forces Q=0 immediately, independent of CLK; during reset CAO follows REQ-021 (Q=0) and ILL=0.
REQ-026 CD deassertion is synchronous to CLK at system level; the first edge after release applies REQ-014.
REQ-027 CD asserted mid-count discards the step in progress; Q is 0 on release.

Structure
REQ-028 Shared package holds the BCD digit width (4), the digit-max constant (9), and a BCD-vector width function of DIGITS.
REQ-029 One sub-module, bcd_digit: one digit with inc/dec, carry/borrow in, terminal flags out; instanced DIGITS times by generate.
REQ-030 Terminal comparison (Q==TERM, Q==0) lives in the top level, not in bcd_digit.

Verification (DIGITS=2 unless noted)
REQ-031 TERM=8'h63, UP=1, CAI=EN=1 from Q=8'h62 -> Q 8'h63 with CAO=1, next edge Q=8'h00 with CAO=0.
REQ-032 Default TERM, UP=0, Q=8'h10 -> 8'h09; from 8'h00 -> 8'h99 with CAO=1 during Q=00.
REQ-033 LD=1 with D=8'h3A -> Q=8'h3A, ILL=1; further CAI=EN=1 edges hold 8'h3A, CAO=0; CS=1 -> Q=0, ILL=0.
REQ-034 CS=LD=1 with D=8'h55 -> Q=8'h00; CD pulse between edges at Q=8'h47 -> Q=0 immediately, counting resumes from 0.
REQ-035 Two instances cascaded (CAO->CAI), DIGITS=1 each, UP=1, from 09/09 -> both digits 0 on one edge.
REQ-036 DIGITS=4, default TERM, UP=1 from 16'h0999 -> 16'h1000; toggle UP=0 -> 16'h0999.
